// File: rtl/serial_compare_sequencer_pkg.sv
// Shared types and constants for the bit-serial comparator sequencer.
package serial_compare_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EN     = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Slice result codes, ordered {lt, eq, gt}
  localparam logic [2:0] CODE_LT = 3'b100;
  localparam logic [2:0] CODE_EQ = 3'b010;
  localparam logic [2:0] CODE_GT = 3'b001;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_compare_sequencer.sv
// Walks power-gated single-bit comparator slices MSB first, one enabled at a
// time, stopping at the first unequal bit; start/done handshake, registered outputs.
module serial_compare_sequencer
  import serial_compare_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] slice_a,
  output logic [WIDTH-1:0] slice_b,
  output logic [WIDTH-1:0] slice_enable,
  input  logic [WIDTH-1:0] slice_lt,
  input  logic [WIDTH-1:0] slice_eq,
  input  logic [WIDTH-1:0] slice_gt,
  output logic             busy,
  output logic             done,
  output logic             less_than,
  output logic             equal_to,
  output logic             greater_than,
  output logic             error
);

  localparam int unsigned IW = clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] slice_a_q, slice_a_d;
  logic [WIDTH-1:0] slice_b_q, slice_b_d;
  logic [WIDTH-1:0] enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       res_q, res_d;
  logic             err_q, err_d;
  logic [2:0]       code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= IDX_MSB;
      slice_a_q <= '0;
      slice_b_q <= '0;
      enable_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      slice_a_q <= slice_a_d;
      slice_b_q <= slice_b_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    slice_a_d = slice_a_q;
    slice_b_d = slice_b_q;
    enable_d  = enable_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    res_d     = res_q;
    err_d     = err_q;
    code      = {slice_lt[idx_q], slice_eq[idx_q], slice_gt[idx_q]};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          slice_a_d = a;
          slice_b_d = b;
          idx_d     = IDX_MSB;
          res_d     = '0;
          err_d     = 1'b0;
          state_d   = EN;
        end
      end
      EN: begin
        enable_d = WIDTH'(1) << idx_q;
        busy_d   = 1'b1;
        state_d  = SAMPLE;
      end
      SAMPLE: begin
        // enable is held through the following EN cycle so the slice settles
        case (code)
          CODE_LT, CODE_GT: begin
            res_d   = code;
            state_d = DONE;
          end
          CODE_EQ: begin
            if (idx_q == '0) begin
              res_d   = CODE_EQ;
              state_d = DONE;
            end else begin
              idx_d   = idx_q - IW'(1);
              state_d = EN;
            end
          end
          default: begin
            err_d   = 1'b1;
            res_d   = '0;
            state_d = DONE;
          end
        endcase
      end
      DONE: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        enable_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign slice_a      = slice_a_q;
  assign slice_b      = slice_b_q;
  assign slice_enable = enable_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign less_than    = res_q[2];
  assign equal_to     = res_q[1];
  assign greater_than = res_q[0];
  assign error        = err_q;

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Bench for serial_compare_sequencer: gated slice model, schedule-level reference
// model checked every cycle, and directed transactions with literal expectations.
module tb_serial_compare_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic [W-1:0] slice_a, slice_b, slice_enable;
  logic [W-1:0] s_lt, s_eq, s_gt;
  logic         busy, done, lt, eq, gt, err;

  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  bit  chk_on = 1'b0;

  logic       inj_en = 1'b0;
  int         inj_bit = 0;
  logic [2:0] inj_code = 3'b000;

  always #5 clk = ~clk;

  serial_compare_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a_in), .b(b_in),
    .slice_a(slice_a), .slice_b(slice_b), .slice_enable(slice_enable),
    .slice_lt(s_lt), .slice_eq(s_eq), .slice_gt(s_gt),
    .busy(busy), .done(done), .less_than(lt), .equal_to(eq),
    .greater_than(gt), .error(err)
  );

  // Power-gated slices: output 000 unless enabled; optional forced code
  always_comb begin
    s_lt = '0;
    s_eq = '0;
    s_gt = '0;
    for (int i = 0; i < W; i++) begin
      if (slice_enable[i]) begin
        if (inj_en && i == inj_bit) begin
          {s_lt[i], s_eq[i], s_gt[i]} = inj_code;
        end else begin
          s_lt[i] = ~slice_a[i] & slice_b[i];
          s_eq[i] = slice_a[i] ~^ slice_b[i];
          s_gt[i] = slice_a[i] & ~slice_b[i];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // MSB-relative step at which operands first differ (last step if equal)
  function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return W - 1 - i;
    end
    return W - 1;
  endfunction

  // Reference model: accepted start at edge mT, done after edge mD
  bit         started = 1'b0;
  int         mT = 0, mD = 0;
  logic [W-1:0] mA = '0, mB = '0;
  logic [2:0] mRes = '0;
  logic       mErr = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      started <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (start && (!started || cyc + 1 > mD)) begin
        started <= 1'b1;
        mT <= cyc + 1;
        mA <= a_in;
        mB <= b_in;
        if (inj_en && (W - 1 - inj_bit) <= first_diff(a_in, b_in)) begin
          mD   <= cyc + 1 + 2 * (W - inj_bit) + 1;
          mRes <= 3'b000;
          mErr <= 1'b1;
        end else begin
          mD   <= cyc + 1 + 2 * (first_diff(a_in, b_in) + 1) + 1;
          mRes <= (a_in > b_in) ? 3'b001 : (a_in < b_in) ? 3'b100 : 3'b010;
          mErr <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [W-1:0] e_en, e_sa, e_sb;
    logic         e_busy, e_done, e_err;
    logic [2:0]   e_res;
    if (chk_on) begin
      e_en = '0; e_sa = '0; e_sb = '0;
      e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_res = '0;
      if (started) begin
        e_sa = mA;
        e_sb = mB;
        if (cyc >= mT + 1 && cyc < mD) begin
          e_busy = 1'b1;
          e_en   = W'(1) << (W - 1 - (cyc - mT - 1) / 2);
        end
        e_done = (cyc == mD);
        if (cyc >= mD - 1) begin
          e_res = mRes;
          e_err = mErr;
        end
      end
      chk("slice_a", slice_a, e_sa);
      chk("slice_b", slice_b, e_sb);
      chk("slice_enable", slice_enable, e_en);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("result", {lt, eq, gt}, e_res);
      chk("error", err, e_err);
      chk("enable_onehot0", ($countones(slice_enable) <= 1), 1);
    end
  end

  // Called at a negedge; returns at the negedge where done is seen
  task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] y, input int lat,
                         input logic [2:0] r, input logic e);
    int t0, got;
    logic [W-1:0] en1;
    got = -1;
    en1 = '0;
    a_in = x; b_in = y; start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (cyc == t0 + 1) en1 = slice_enable;
      if (done) begin
        got = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    chk("txn_latency", 64'(got), 64'(lat));
    chk("txn_result", {lt, eq, gt}, r);
    chk("txn_error", err, e);
    chk("txn_first_enable", en1, W'(1) << (W - 1));
  endtask

  initial begin : stim
    int dcount;
    #1 reset = 1'b1;
    #1;
    chk("reset_outputs", {slice_a, slice_b, slice_enable, busy, done, lt, eq, gt, err}, '0);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_txn(8'hA5, 8'h25, 3, 3'b001, 1'b0);
    run_txn(8'h3C, 8'h3C, 17, 3'b010, 1'b0);   // back-to-back start
    run_txn(8'h10, 8'h11, 17, 3'b100, 1'b0);
    run_txn(8'h4F, 8'h5F, 9, 3'b100, 1'b0);

    // starts during a busy run are ignored
    @(negedge clk);
    a_in = 8'h5A; b_in = 8'h5A; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a_in = 8'hFF; b_in = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    dcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("single_done", 64'(dcount), 64'd1);
    chk("operands_kept", {slice_a, slice_b}, 16'h5A5A);
    chk("busy_run_result", {lt, eq, gt}, 3'b010);

    // invalid slice code on the MSB
    inj_en = 1'b1; inj_bit = 7; inj_code = 3'b011;
    run_txn(8'hA5, 8'h25, 3, 3'b000, 1'b1);
    @(negedge clk);
    inj_en = 1'b0;

    // asynchronous reset mid-run
    @(negedge clk);
    a_in = 8'h3C; b_in = 8'h3C; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {slice_a, slice_b, slice_enable, busy, done, lt, eq, gt, err}, '0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("no_done_after_abort", 64'(dcount), 64'd0);
    run_txn(8'h4F, 8'h5F, 9, 3'b100, 1'b0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
